// File: rtl/hmmm_pkg.sv
// Shared types for the multiply/divide unit: operation encoding and FSM states.
package hmmm_pkg;

  typedef enum logic [1:0] {
    OpMul  = 2'b00,
    OpDiv  = 2'b01,
    OpMod  = 2'b10,
    OpRsvd = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } muldiv_state_t;

endpackage

// File: rtl/mux3.sv
// Three-input word mux; selects d0/d1/d2 by sel 0/1/2, zero for sel 3.
module mux3 #(
  parameter int unsigned W = 16
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  output logic [W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide/modulo: radix-2 on magnitudes for W cycles,
// then one sign-fix cycle and a one-cycle done pulse.
module muldiv_unit
  import hmmm_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         div_by_zero
);

  localparam int unsigned CntW = $clog2(W + 1);

  muldiv_state_t r_state, w_state_next;
  muldiv_op_t    r_op;
  logic [CntW-1:0] r_cnt;
  logic          r_sign_a, r_sign_b;
  // r_x: MUL multiplicand (shifts left) / DIV dividend becoming quotient.
  // r_y: MUL multiplier (shifts right) / DIV divisor.
  // r_acc: MUL partial product / DIV partial remainder.
  logic [W-1:0]  r_x, r_y, r_acc;
  logic [W-1:0]  r_result;
  logic          r_dbz;

  logic [W-1:0]  w_a_mag, w_b_mag;
  logic [W-1:0]  w_x_next, w_y_next, w_acc_next;
  logic [W:0]    w_rem_shift, w_diff;
  logic [W-1:0]  w_prod_s, w_quo_s, w_rem_s, w_sel, w_fix_result;
  logic          w_sign_diff, w_dbz;

  assign w_a_mag = a[W-1] ? -a : a;
  assign w_b_mag = b[W-1] ? -b : b;

  always_comb begin
    w_x_next    = r_x;
    w_y_next    = r_y;
    w_acc_next  = r_acc;
    w_rem_shift = '0;
    w_diff      = '0;
    if (r_op == OpMul) begin
      if (r_y[0]) begin
        w_acc_next = r_acc + r_x;
      end
      w_x_next = r_x << 1;
      w_y_next = r_y >> 1;
    end else begin
      w_rem_shift = {r_acc, r_x[W-1]};
      w_diff      = w_rem_shift - {1'b0, r_y};
      if (!w_diff[W]) begin
        w_acc_next = w_diff[W-1:0];
        w_x_next   = {r_x[W-2:0], 1'b1};
      end else begin
        w_acc_next = w_rem_shift[W-1:0];
        w_x_next   = {r_x[W-2:0], 1'b0};
      end
    end
  end

  assign w_sign_diff = r_sign_a ^ r_sign_b;
  assign w_prod_s    = w_sign_diff ? -r_acc : r_acc;
  assign w_quo_s     = w_sign_diff ? -r_x : r_x;
  assign w_rem_s     = r_sign_a ? -r_acc : r_acc;
  assign w_dbz       = ((r_op == OpDiv) || (r_op == OpMod)) && (r_y == '0);

  mux3 #(
    .W(W)
  ) u_mux3 (
    .i_sel(r_op),
    .i_d0 (w_prod_s),
    .i_d1 (w_quo_s),
    .i_d2 (w_rem_s),
    .o_y  (w_sel)
  );

  assign w_fix_result = (w_dbz || (r_op == OpRsvd)) ? '0 : w_sel;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (start) w_state_next = StCalc;
      StCalc:  if (r_cnt == CntW'(W - 1)) w_state_next = StFix;
      StFix:   w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_op     <= OpMul;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_op     <= muldiv_op_t'(op);
            r_sign_a <= a[W-1];
            r_sign_b <= b[W-1];
            r_x      <= w_a_mag;
            r_y      <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        StCalc: begin
          r_x   <= w_x_next;
          r_y   <= w_y_next;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CntW'(1);
        end
        StFix: begin
          r_result <= w_fix_result;
          r_dbz    <= w_dbz;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != StIdle);
  assign done        = (r_state == StDone);
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter W, default 16, datapath width in bits (hmmm word).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port op, input, 2, operation: 00 MUL, 01 DIV, 10 MOD, 11 reserved.
REQ-006 SHALL have ports a, b, input, W each, signed two's-complement operands (a op b).
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking valid result.
REQ-009 SHALL have port result, output, W, signed result feeding the writeback result mux.
REQ-010 SHALL have port div_by_zero, output, 1, valid with done: DIV/MOD with b == 0.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-012 SHALL in IDLE accept start: latch op, |a|, |b|, operand signs; clear iteration counter; go to CALC.
REQ-013 SHALL ignore start in every state other than IDLE; operands are not re-sampled.
REQ-014 SHALL in CALC perform one radix-2 step per cycle for exactly W cycles: MUL shift-add on magnitudes, DIV/MOD restoring division on magnitudes.
REQ-015 SHALL after the W-th CALC cycle enter FIX for one cycle to apply sign correction and select the result.
REQ-016 SHALL sign-correct as follows: product negated if operand signs differ; quotient truncates toward zero; remainder takes the sign of a.
REQ-017 SHALL return the low W bits of the product for MUL (overflow wraps silently).
REQ-018 SHALL return 0x8000 for DIV and 0 for MOD when a = most-negative value and b = -1 (W=16).
REQ-019 SHALL for DIV/MOD with b == 0 keep the fixed latency, return result 0 and assert div_by_zero with done.
REQ-020 SHALL for op 11 keep the fixed latency, return result 0 and leave div_by_zero low.
REQ-021 SHALL in DONE assert done for exactly one cycle, then return to IDLE.
REQ-022 SHALL assert done exactly W+2 cycles after the edge that sampled start (W=16: 18 cycles).
REQ-023 SHALL hold busy high from the cycle after start is sampled through the DONE cycle inclusive.
REQ-024 SHALL update result and div_by_zero only on entry to DONE and hold them until the next DONE.
REQ-025 SHALL allow a new start in the cycle immediately after DONE (back-to-back operations).

Reset
REQ-026 SHALL on reset_n low, asynchronously and regardless of state (including mid-CALC), enter IDLE with busy=0, done=0, result=0, div_by_zero=0 and counter cleared.
REQ-027 SHALL not produce done for any operation interrupted by reset.

Structure
REQ-028 SHALL take the op encoding (muldiv_op_t) and FSM state type (muldiv_state_t) from the shared package hmmm_pkg.
REQ-029 SHALL instantiate the existing mux3 (W wide) to select product, quotient or remainder in FIX.
REQ-030 SHALL hold all sequential logic in a single always_ff block; next-state logic in always_comb.

Verification
REQ-031 SHALL cover: MUL a=7, b=-3 -> done at cycle 18, result 0xFFEB, div_by_zero=0.
REQ-032 SHALL cover: DIV a=-7, b=2 -> 0xFFFD; MOD a=-7, b=2 -> 0xFFFF; MOD a=7, b=-2 -> 0x0001.
REQ-033 SHALL cover: DIV a=5, b=0 -> done at cycle 18, result 0x0000, div_by_zero=1; next MUL 2*3 -> 0x0006, div_by_zero=0.
REQ-034 SHALL cover: DIV a=0x8000, b=-1 -> 0x8000; MUL 0x4000*4 -> 0x0000.
REQ-035 SHALL cover: start pulsed with different operands at cycles 5 and 10 of a MUL 3*4 -> ignored, result 0x000C, single done.
REQ-036 SHALL cover: reset_n low at cycle 8 of a DIV -> busy=0, result=0 immediately, no done; then a fresh DIV 100/7 -> 0x000E.
